// File: rtl/arbiter_lru_n.sv
// rtl/arbiter_lru_n.sv - N-way least-recently-granted arbiter with optional grant lock
module arbiter_lru_n #(
  parameter int N       = 4,
  parameter int LOCK_EN = 1,
  localparam int IDX_W  = (N > 2) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [N-1:0]     req_vector,
  input  logic [N-1:0]     lock_vector,
  output logic [N-1:0]     grant_vector,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("arbiter_lru_n: N must be in the range 2..16");
  end

  // order_q[0] is the least recently granted requester, order_q[N-1] the most recent
  logic [IDX_W-1:0] order_q [N];
  logic [IDX_W-1:0] order_d [N];
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;

  logic             hold;
  logic             found;
  logic [IDX_W-1:0] win;
  int               pos;

  always_comb begin
    hold    = (LOCK_EN != 0) && valid_q && req_vector[idx_q] && lock_vector[idx_q];
    found   = 1'b0;
    win     = '0;
    pos     = 0;
    order_d = order_q;
    grant_d = '0;
    idx_d   = '0;
    valid_d = 1'b0;

    for (int p = 0; p < N; p++) begin
      if (!found && req_vector[order_q[p]]) begin
        found = 1'b1;
        win   = order_q[p];
        pos   = p;
      end
    end

    if (enable) begin
      if (hold) begin
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = 1'b1;
      end else if (found) begin
        grant_d[win] = 1'b1;
        idx_d        = win;
        valid_d      = 1'b1;
        // Winner moves to the MRU slot; everything behind it slides one toward LRU
        for (int k = 0; k < N - 1; k++) begin
          if (k >= pos) begin
            order_d[k] = order_q[k+1];
          end
        end
        order_d[N-1] = win;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        order_q[i] <= IDX_W'(i);
      end
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      order_q <= order_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign grant_vector = grant_q;
  assign grant_valid  = valid_q;
  assign grant_idx    = idx_q;

endmodule

// File: tb/tb_arbiter_lru_n.sv
// tb/tb_arbiter_lru_n.sv - self-checking bench for arbiter_lru_n (N=4, LOCK_EN=1)
module tb_arbiter_lru_n;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         enable = 1'b0;
  logic [N-1:0] req_vector = '0;
  logic [N-1:0] lock_vector = '0;
  logic [N-1:0] grant_vector;
  logic         grant_valid;
  logic [1:0]   grant_idx;

  int passed = 0;
  int total  = 0;

  arbiter_lru_n #(.N(N), .LOCK_EN(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .req_vector   (req_vector),
    .lock_vector  (lock_vector),
    .grant_vector (grant_vector),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // Request vector as seen by the DUT at the most recent rising edge
  logic [N-1:0] req_s = '0;
  always @(posedge clk) req_s <= req_vector;

  always @(negedge clk) begin
    if (reset_n) begin
      check("inv_onehot0", int'($onehot0(grant_vector)), 1);
      check("inv_valid_or", int'(grant_valid), int'(|grant_vector));
      check("inv_idx", int'(grant_valid ? (grant_vector == (4'b1 << grant_idx)) : (grant_idx == 0)), 1);
      check("inv_req_backed", int'((grant_vector & ~req_s) == 0), 1);
    end
  end

  // Reference model: LRU list held as a queue, front = least recently granted
  int lru[$];
  int cur;

  task automatic model_reset();
    lru = {0, 1, 2, 3};
    cur = -1;
  endtask

  task automatic model_step(input bit en, input logic [N-1:0] req, input logic [N-1:0] lock);
    int hit;
    if (!en) begin
      cur = -1;
    end else if (!(cur >= 0 && req[cur] && lock[cur])) begin
      hit = -1;
      for (int p = 0; p < lru.size(); p++)
        if (hit < 0 && req[lru[p]]) hit = p;
      if (hit < 0) cur = -1;
      else begin
        cur = lru[hit];
        lru.delete(hit);
        lru.push_back(cur);
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_async_grant", int'(grant_vector), 0);
    check("rst_async_valid", int'(grant_valid), 0);
    check("rst_async_idx", int'(grant_idx), 0);
    enable = 1'b1; req_vector = '1; lock_vector = '0;
    @(posedge clk); #1;
    check("rst_held_grant", int'(grant_vector), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic drive(input bit en, input logic [N-1:0] req, input logic [N-1:0] lock);
    enable = en; req_vector = req; lock_vector = lock;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit           rst;
    bit           en;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N-1:0] g;
    int           idx;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit en, input logic [N-1:0] req,
                     input logic [N-1:0] lock, input logic [N-1:0] g, input int idx);
    vec_t v;
    v.rst = rst; v.en = en; v.req = req; v.lock = lock; v.g = g; v.idx = idx;
    tbl.push_back(v);
  endtask

  initial begin
    // Full request rotation
    add(1, 1, 4'b1111, 4'b0000, 4'b0001, 0);
    add(0, 1, 4'b1111, 4'b0000, 4'b0010, 1);
    add(0, 1, 4'b1111, 4'b0000, 4'b0100, 2);
    add(0, 1, 4'b1111, 4'b0000, 4'b1000, 3);
    add(0, 1, 4'b1111, 4'b0000, 4'b0001, 0);
    // Sparse requests
    add(1, 1, 4'b0101, 4'b0000, 4'b0001, 0);
    add(0, 1, 4'b0101, 4'b0000, 4'b0100, 2);
    add(0, 1, 4'b0011, 4'b0000, 4'b0010, 1);
    add(0, 1, 4'b0110, 4'b0000, 4'b0100, 2);
    // Lock hold then release
    add(1, 1, 4'b1111, 4'b0001, 4'b0001, 0);
    add(0, 1, 4'b1111, 4'b0001, 4'b0001, 0);
    add(0, 1, 4'b1111, 4'b0001, 4'b0001, 0);
    add(0, 1, 4'b1111, 4'b0001, 4'b0001, 0);
    add(0, 1, 4'b1111, 4'b0000, 4'b0010, 1);
    // Enable low freezes order, idle request, foreign lock, dropped-req lock, MRU regrant
    add(1, 1, 4'b1111, 4'b0000, 4'b0001, 0);
    add(0, 0, 4'b1111, 4'b0000, 4'b0000, 0);
    add(0, 0, 4'b1111, 4'b0000, 4'b0000, 0);
    add(0, 0, 4'b1111, 4'b0000, 4'b0000, 0);
    add(0, 1, 4'b1111, 4'b0000, 4'b0010, 1);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 0);
    add(0, 1, 4'b1111, 4'b0000, 4'b0100, 2);
    add(0, 1, 4'b1111, 4'b1000, 4'b1000, 3);
    add(0, 1, 4'b0111, 4'b1000, 4'b0001, 0);
    add(0, 1, 4'b0001, 4'b0000, 4'b0001, 0);
    add(0, 1, 4'b0010, 4'b0000, 4'b0010, 1);
    add(0, 1, 4'b1111, 4'b0000, 4'b0100, 2);

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].en, tbl[i].req, tbl[i].lock);
      check($sformatf("tbl%0d_grant", i), int'(grant_vector), int'(tbl[i].g));
      check($sformatf("tbl%0d_idx", i), int'(grant_idx), tbl[i].idx);
      check($sformatf("tbl%0d_valid", i), int'(grant_valid), int'(tbl[i].g != 0));
    end

    // Reset asserted between edges while a lock is held on requester 2
    do_reset();
    drive(1, 4'b1111, 4'b0000);
    drive(1, 4'b1111, 4'b0000);
    drive(1, 4'b1111, 4'b0100);
    check("midlock_grant", int'(grant_vector), 4'b0100);
    drive(1, 4'b1111, 4'b0100);
    check("midlock_held", int'(grant_vector), 4'b0100);
    do_reset();
    drive(1, 4'b1111, 4'b0100);
    check("post_reset_grant", int'(grant_vector), 4'b0001);
    check("post_reset_idx", int'(grant_idx), 0);

    // Random stimulus against the queue model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bit           en;
      logic [N-1:0] rq, lk;
      int           eg;
      en = ($urandom_range(0, 9) != 0);
      rq = N'($urandom);
      lk = N'($urandom);
      if (c == 300) do_reset();
      drive(en, rq, lk);
      model_step(en, rq, lk);
      eg = (cur >= 0) ? (1 << cur) : 0;
      check($sformatf("rnd%0d_grant", c), int'(grant_vector), eg);
      check($sformatf("rnd%0d_idx", c), int'(grant_idx), (cur >= 0) ? cur : 0);
      check($sformatf("rnd%0d_valid", c), int'(grant_valid), int'(cur >= 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arbiter_lru_n.md
ARBITER_LRU_N -- requirements
Module: arbiter_lru_n

Interface
REQ-001 Parameter: N, default 4, number of requesters; legal range 2..16; out-of-range values SHALL fail elaboration.
REQ-002 Parameter: LOCK_EN, default 1, enables grant locking; 0 SHALL make lock_vector ignored.
REQ-003 Derived localparam: IDX_W = max(1, clog2(N)), the width of grant_idx.
REQ-004 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: enable  input  1  arbitration enable, sampled on the clk rising edge.
REQ-007 Port: req_vector  input  N  request per requester; bit i is requester i.
REQ-008 Port: lock_vector  input  N  bit i high requests that requester i keep its current grant.
REQ-009 Port: grant_vector  output  N  registered one-hot-or-zero grant.
REQ-010 Port: grant_valid  output  1  registered; equals OR of grant_vector.
REQ-011 Port: grant_idx  output  IDX_W  registered binary index of the granted requester; 0 when grant_valid=0.

Function
REQ-012 The block SHALL hold an LRU order: a list of N distinct requester indices, position 0 = least recently granted (highest priority), position N-1 = most recently granted.
REQ-013 Grant latency SHALL be exactly one cycle: outputs after edge k are a function only of inputs sampled at edge k and state before edge k.
REQ-014 Per edge, enable=0: grant_vector, grant_valid and grant_idx SHALL clear to 0; LRU order frozen; any lock released.
REQ-015 Lock hold: at an edge with enable=1, LOCK_EN=1, current grantee i, req_vector[i]=1 and lock_vector[i]=1, the grant SHALL remain on i and the LRU order SHALL be unchanged.
REQ-016 Lock applies only to the current grantee; lock bits of non-granted requesters SHALL be ignored.
REQ-017 Lock with req dropped: lock_vector[i]=1 with req_vector[i]=0 SHALL NOT hold the grant; normal arbitration applies.
REQ-018 Normal arbitration, enable=1 with no lock hold: grant SHALL go to the requesting index at the lowest LRU position.
REQ-019 On a normal grant to j, j SHALL move to position N-1; entries after j's old position SHALL shift down one; entries before it SHALL stay.
REQ-020 Re-granting the MRU requester (only requester, e.g.) SHALL be legal; the order stays unchanged.
REQ-021 enable=1 with req_vector=0: outputs SHALL clear to 0 and the order SHALL stay unchanged.
REQ-022 grant_vector SHALL never have more than one bit set; grant_vector bit i SHALL imply req_vector[i]=1 at the sampling edge.
REQ-023 Under continuous full request without locks, every requester SHALL be granted exactly once per N consecutive grants, so there is no starvation.

Reset
REQ-024 reset_n=0 SHALL immediately clear grant_vector, grant_valid and grant_idx to 0, with no clock edge required.
REQ-025 reset_n=0 SHALL set the LRU order to 0,1,...,N-1 (requester 0 is LRU) and release any lock.
REQ-026 Reset assertion mid-lock or mid-grant SHALL abort it; after deassertion, the first edge SHALL arbitrate from the reset order.
REQ-027 Deassertion SHALL be treated as synchronous to clk; the first state update SHALL be at the first rising edge with reset_n=1.

Verification (N=4, LOCK_EN=1)
REQ-028 Reset; enable=1, req=1111, lock=0000 for 5 edges -> grants 0001,0010,0100,1000,0001; grant_idx 0,1,2,3,0.
REQ-029 Reset; enable=1, lock=0; req 0101,0101,0011,0110 -> grants 0001,0100,0010,0100.
REQ-030 Reset; req=1111 and lock=0001 for 4 edges -> 0001 held all 4; then lock=0000 -> next grant 0010.
REQ-031 Reset; grant 0001; then enable=0, req=1111 for 3 edges -> outputs 0 for those edges; then enable=1 -> grant 0010, showing the order was frozen.
REQ-032 During a held lock on 0100, drive reset_n low between edges -> outputs become 0 before the next edge; release, req=1111 -> grant 0001.
REQ-033 Throughout all scenarios, assertions SHALL check one-hot-or-zero grant_vector, grant_valid equal to OR of grant_vector, grant_idx consistent with grant_vector, and each grant bit backed by its request.
